// File: rtl/gear_param_sched.sv
// Table-driven gear-to-link-parameter scheduler: qualifies an asynchronous gear code,
// looks it up in a programmable table and hands the parameter word to the modem via req/ack.
module gear_param_sched #(
   parameter int GEAR_W      = 8,
   parameter int PARAM_W     = 40,
   parameter int DEPTH       = 32,
   parameter int STABLE_CNT  = 4,
   parameter int ACK_TIMEOUT = 1023,
   parameter logic [PARAM_W-1:0] PARAM_DEFAULT = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [GEAR_W-1:0]        gear_in,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic                     cfg_valid,
   input  logic [GEAR_W-1:0]        cfg_code,
   input  logic [PARAM_W-1:0]       cfg_param,
   output logic [PARAM_W-1:0]       param_out,
   output logic                     param_req,
   input  logic                     param_ack,
   output logic                     busy,
   output logic                     unknown_err,
   output logic                     timeout_err,
   input  logic                     err_clr
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(STABLE_CNT + 1);
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_REQ  = 2'd2;

   logic [GEAR_W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               qual_q, qual_d;
   logic [GEAR_W-1:0]  qcode_q, qcode_d;
   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [GEAR_W-1:0]  cand_q, cand_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [PARAM_W-1:0] param_q, param_d;
   logic               req_q, req_d;
   logic               act_valid_q, act_valid_d;
   logic [GEAR_W-1:0]  act_code_q, act_code_d;
   logic               miss_valid_q, miss_valid_d;
   logic [GEAR_W-1:0]  miss_code_q, miss_code_d;
   logic               unk_q, unk_d, tmo_err_q, tmo_err_d;
   logic               unk_set, tmo_set, hit;

   logic [DEPTH-1:0]   tbl_valid_q, tbl_valid_d;
   logic [GEAR_W-1:0]  tbl_code_q [DEPTH];
   logic [GEAR_W-1:0]  tbl_code_d [DEPTH];
   logic [PARAM_W-1:0] tbl_param_q [DEPTH];
   logic [PARAM_W-1:0] tbl_param_d [DEPTH];

   always_comb begin
      tbl_valid_d = tbl_valid_q;
      tbl_code_d  = tbl_code_q;
      tbl_param_d = tbl_param_q;
      if (cfg_we) begin
         tbl_valid_d[cfg_addr] = cfg_valid;
         tbl_code_d[cfg_addr]  = cfg_code;
         tbl_param_d[cfg_addr] = cfg_param;
      end
   end

   // Qualification is registered so the FSM always sees a code/flag pair from the same sample.
   always_comb begin
      sync1_d = gear_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      if (sync2_q != prev_q)
         cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_W'(STABLE_CNT))
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;
      qual_d  = (cnt_q == CNT_W'(STABLE_CNT));
      qcode_d = prev_q;
   end

   assign hit = tbl_valid_q[idx_q] && (tbl_code_q[idx_q] == cand_q);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cand_d       = cand_q;
      tmo_d        = tmo_q;
      param_d      = param_q;
      req_d        = req_q;
      act_valid_d  = act_valid_q;
      act_code_d   = act_code_q;
      miss_valid_d = miss_valid_q;
      miss_code_d  = miss_code_q;
      unk_set      = 1'b0;
      tmo_set      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (qual_q && (!act_valid_q || (qcode_q != act_code_q)) &&
                !(miss_valid_q && (qcode_q == miss_code_q))) begin
               cand_d  = qcode_q;
               idx_d   = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // A table write invalidates whatever this cycle examined, so restart from entry 0.
            if (cfg_we) begin
               idx_d = '0;
            end else if (hit) begin
               param_d = tbl_param_q[idx_q];
               req_d   = 1'b1;
               tmo_d   = '0;
               state_d = ST_REQ;
            end else if (idx_q == IDX_W'(DEPTH - 1)) begin
               unk_set      = 1'b1;
               miss_valid_d = 1'b1;
               miss_code_d  = cand_q;
               state_d      = ST_IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_REQ: begin
            if (param_ack || (tmo_q == TMO_W'(ACK_TIMEOUT - 1))) begin
               tmo_set     = !param_ack;
               req_d       = 1'b0;
               act_code_d  = cand_q;
               act_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (cfg_we) begin
         act_valid_d  = 1'b0;
         miss_valid_d = 1'b0;
      end
      unk_d     = unk_set | (unk_q & ~err_clr);
      tmo_err_d = tmo_set | (tmo_err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         prev_q       <= '0;
         cnt_q        <= '0;
         qual_q       <= 1'b0;
         qcode_q      <= '0;
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         cand_q       <= '0;
         tmo_q        <= '0;
         param_q      <= PARAM_DEFAULT;
         req_q        <= 1'b0;
         act_valid_q  <= 1'b0;
         act_code_q   <= '0;
         miss_valid_q <= 1'b0;
         miss_code_q  <= '0;
         unk_q        <= 1'b0;
         tmo_err_q    <= 1'b0;
         tbl_valid_q  <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         cnt_q        <= cnt_d;
         qual_q       <= qual_d;
         qcode_q      <= qcode_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         cand_q       <= cand_d;
         tmo_q        <= tmo_d;
         param_q      <= param_d;
         req_q        <= req_d;
         act_valid_q  <= act_valid_d;
         act_code_q   <= act_code_d;
         miss_valid_q <= miss_valid_d;
         miss_code_q  <= miss_code_d;
         unk_q        <= unk_d;
         tmo_err_q    <= tmo_err_d;
         tbl_valid_q  <= tbl_valid_d;
      end
   end

   // Entry payloads need no reset; the valid bits alone gate every lookup.
   always_ff @(posedge clk) begin
      tbl_code_q  <= tbl_code_d;
      tbl_param_q <= tbl_param_d;
   end

   assign param_out   = param_q;
   assign param_req   = req_q;
   assign busy        = (state_q != ST_IDLE);
   assign unknown_err = unk_q;
   assign timeout_err = tmo_err_q;
endmodule

// File: tb/tb_gear_param_sched.sv
// Directed bench for gear_param_sched: latency, glitch rejection, unknown codes,
// ack timeout, table rewrites, duplicate entries and asynchronous reset.
module tb_gear_param_sched;
   localparam logic [39:0] P_8E_OLD = 40'h05_0C_06_0D_08;
   localparam logic [39:0] P_8E_NEW = 40'h05_0C_07_0D_04;
   localparam logic [39:0] P_42     = 40'h11_22_33_44_55;
   localparam logic [39:0] P_55_E2  = 40'hAA_00_00_00_02;
   localparam logic [39:0] P_55_E9  = 40'h99_00_00_00_09;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  gear_in = 8'h00;
   logic        cfg_we = 1'b0;
   logic [4:0]  cfg_addr = '0;
   logic        cfg_valid = 1'b0;
   logic [7:0]  cfg_code = '0;
   logic [39:0] cfg_param = '0;
   logic [39:0] param_out;
   logic        param_req;
   logic        param_ack = 1'b0;
   logic        busy;
   logic        unknown_err;
   logic        timeout_err;
   logic        err_clr = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   gear_param_sched dut (
      .clk(clk), .rst_n(rst_n), .gear_in(gear_in),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
      .cfg_code(cfg_code), .cfg_param(cfg_param),
      .param_out(param_out), .param_req(param_req), .param_ack(param_ack),
      .busy(busy), .unknown_err(unknown_err), .timeout_err(timeout_err),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic cfg_write(input logic [4:0] a, input logic v, input logic [7:0] c,
                            input logic [39:0] p);
      cfg_we = 1'b1; cfg_addr = a; cfg_valid = v; cfg_code = c; cfg_param = p;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_req_rise(input int budget, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!param_req && n < budget);
   endtask

   task automatic do_ack();
      param_ack = 1'b1;
      @(posedge clk); #1;
      param_ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests_run++;
      if (param_out !== 40'h0 || param_req !== 1'b0 || busy !== 1'b0 ||
          unknown_err !== 1'b0 || timeout_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_values: got out=%h req=%b busy=%b unk=%b tmo=%b expected all zero",
                  param_out, param_req, busy, unknown_err, timeout_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_program();
      cfg_write(5'd3, 1'b1, 8'h8E, P_8E_OLD);
      cfg_write(5'd5, 1'b1, 8'h42, P_42);
      cfg_write(5'd2, 1'b1, 8'h55, P_55_E2);
      cfg_write(5'd9, 1'b1, 8'h55, P_55_E9);
      // gear_in is 0 since reset, which is not in the table
      repeat (60) @(negedge clk);
      tests_run++;
      if (unknown_err !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL code0_unknown: got unk=%b busy=%b expected unk=1 busy=0", unknown_err, busy);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      tests_run++;
      if (unknown_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL err_clr_initial: got %b expected 0", unknown_err);
      end
   endtask

   task automatic test_apply();
      int n;
      gear_in = 8'h8E;
      @(posedge clk);
      wait_req_rise(100, n);
      tests_run++;
      if (n != 11) begin
         tests_failed++;
         $display("[TB] FAIL apply_latency: got %0d expected 11", n);
      end
      tests_run++;
      if (param_out !== P_8E_OLD || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL apply_param: got %h busy=%b expected %h busy=1", param_out, busy, P_8E_OLD);
      end
      do_ack();
      tests_run++;
      if (param_req !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL apply_ack: got req=%b busy=%b expected 0 0", param_req, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_glitch();
      int bad = 0;
      gear_in = 8'h8F;
      repeat (3) @(negedge clk);
      gear_in = 8'h8E;
      repeat (25) begin
         @(posedge clk); #1;
         if (busy || param_req) bad++;
      end
      tests_run++;
      if (bad != 0 || param_out !== P_8E_OLD) begin
         tests_failed++;
         $display("[TB] FAIL glitch: got active_cycles=%0d out=%h expected 0 %h", bad, param_out, P_8E_OLD);
      end
      @(negedge clk);
   endtask

   task automatic test_unknown();
      int n = 0;
      int bad = 0;
      gear_in = 8'h77;
      @(posedge clk);
      do begin
         @(posedge clk); #1;
         n++;
      end while (!unknown_err && n < 100);
      tests_run++;
      if (n != 39) begin
         tests_failed++;
         $display("[TB] FAIL unknown_latency: got %0d expected 39", n);
      end
      tests_run++;
      if (param_out !== P_8E_OLD || param_req !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL unknown_hold: got out=%h req=%b expected %h 0", param_out, param_req, P_8E_OLD);
      end
      repeat (40) begin
         @(posedge clk); #1;
         if (busy || param_req) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL unknown_no_rescan: got busy_cycles=%0d expected 0", bad);
      end
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      tests_run++;
      if (unknown_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL unknown_clear: got %b expected 0", unknown_err);
      end
   endtask

   task automatic test_timeout();
      int n;
      int bad = 0;
      gear_in = 8'h42;
      @(posedge clk);
      wait_req_rise(100, n);
      tests_run++;
      if (n != 13 || param_out !== P_42) begin
         tests_failed++;
         $display("[TB] FAIL timeout_req: got lat=%0d out=%h expected 13 %h", n, param_out, P_42);
      end
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (param_req && n < 1100);
      tests_run++;
      if (n != 1023) begin
         tests_failed++;
         $display("[TB] FAIL timeout_cycles: got %0d expected 1023", n);
      end
      tests_run++;
      if (timeout_err !== 1'b1 || param_out !== P_42 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_state: got err=%b out=%h busy=%b expected 1 %h 0",
                  timeout_err, param_out, busy, P_42);
      end
      repeat (30) begin
         @(posedge clk); #1;
         if (busy || param_req) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_no_rereq: got busy_cycles=%0d expected 0", bad);
      end
      @(negedge clk);
   endtask

   task automatic test_rewrite();
      int n;
      gear_in = 8'h8E;
      @(posedge clk);
      wait_req_rise(100, n);
      do_ack();
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 5'd3; cfg_valid = 1'b1; cfg_code = 8'h8E; cfg_param = P_8E_NEW;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      wait_req_rise(100, n);
      tests_run++;
      if (n != 5 || param_out !== P_8E_NEW) begin
         tests_failed++;
         $display("[TB] FAIL rewrite_idle: got lat=%0d out=%h expected 5 %h", n, param_out, P_8E_NEW);
      end
      do_ack();
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 5'd3; cfg_valid = 1'b1; cfg_code = 8'h8E; cfg_param = P_8E_NEW;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rewrite_scanning: got busy=%b expected 1", busy);
      end
      cfg_we = 1'b1; cfg_addr = 5'd20; cfg_valid = 1'b0; cfg_code = 8'h00; cfg_param = '0;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      wait_req_rise(100, n);
      tests_run++;
      if (n + 3 != 7 || param_out !== P_8E_NEW) begin
         tests_failed++;
         $display("[TB] FAIL rewrite_midscan: got lat=%0d out=%h expected 7 %h", n + 3, param_out, P_8E_NEW);
      end
      do_ack();
      @(negedge clk);
   endtask

   task automatic test_duplicate_reset();
      int n;
      int req_seen = 0;
      gear_in = 8'h55;
      @(posedge clk);
      wait_req_rise(100, n);
      tests_run++;
      if (n != 10 || param_out !== P_55_E2) begin
         tests_failed++;
         $display("[TB] FAIL duplicate_lowest: got lat=%0d out=%h expected 10 %h", n, param_out, P_55_E2);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (param_out !== 40'h0 || param_req !== 1'b0 || busy !== 1'b0 ||
          unknown_err !== 1'b0 || timeout_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got out=%h req=%b busy=%b unk=%b tmo=%b expected all zero",
                  param_out, param_req, busy, unknown_err, timeout_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) begin
         @(posedge clk); #1;
         if (param_req) req_seen++;
      end
      tests_run++;
      if (unknown_err !== 1'b1 || req_seen != 0) begin
         tests_failed++;
         $display("[TB] FAIL table_cleared: got unk=%b req_cycles=%0d expected 1 0", unknown_err, req_seen);
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_apply();
      test_glitch();
      test_unknown();
      test_timeout();
      test_rewrite();
      test_duplicate_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
